// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU, DMA and data-RAM port bundle for mem_port_arbiter
// slave is the arbiter's view; master is the view of the CPU/DMA/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_continue;

  logic              dma_req;
  logic              dma_wr;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_continue,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_continue,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-RAM port arbiter, CPU priority with DMA starvation guard
// Optional MEM_ARB_PERF_EN adds cpu_stall_cnt / dma_xfer_cnt performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]         cpu_stall_cnt,
  output logic [15:0]         dma_xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } state_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_CPU_RUN);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;

  logic              cpu_req;
  logic              force_dma;

  logic              ram_en_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              dma_gnt_c;
  logic              dma_done_c;
  logic              cpu_continue_c;
  logic [DATA_W-1:0] cpu_rdata_c;
  logic [DATA_W-1:0] dma_rdata_c;

  assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign force_dma = bus.dma_req & (starve_cnt == MAX_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_nxt     = starve_cnt;
    ram_en_c       = 1'b0;
    ram_we_c       = 1'b0;
    ram_addr_c     = '0;
    ram_wdata_c    = '0;
    dma_gnt_c      = 1'b0;
    dma_done_c     = 1'b0;
    cpu_continue_c = 1'b1;
    cpu_rdata_c    = '0;
    dma_rdata_c    = '0;

    case (state)
      IDLE: begin
        if (cpu_req && !force_dma) begin
          ram_en_c    = 1'b1;
          ram_we_c    = bus.cpu_wr;
          ram_addr_c  = bus.cpu_addr;
          ram_wdata_c = bus.cpu_wdata;
          if (!bus.cpu_wr) begin
            cpu_continue_c = 1'b0;
            state_nxt      = CPU_RD;
          end
          if (bus.dma_req && (starve_cnt != MAX_RUN)) begin
            starve_nxt = starve_cnt + 4'd1;
          end
        end else if (bus.dma_req) begin
          dma_gnt_c      = 1'b1;
          ram_en_c       = 1'b1;
          ram_we_c       = bus.dma_wr;
          ram_addr_c     = bus.dma_addr;
          ram_wdata_c    = bus.dma_wdata;
          starve_nxt     = 4'd0;
          cpu_continue_c = ~cpu_req;
          // A DMA write completes at this edge; a read returns next cycle.
          if (bus.dma_wr) begin
            dma_done_c = 1'b1;
          end else begin
            state_nxt = DMA_RD;
          end
        end
        if (!bus.dma_req) begin
          starve_nxt = 4'd0;
        end
      end

      CPU_RD: begin
        cpu_rdata_c = bus.ram_rdata;
        state_nxt   = IDLE;
      end

      DMA_RD: begin
        dma_rdata_c    = bus.ram_rdata;
        dma_done_c     = 1'b1;
        cpu_continue_c = ~cpu_req;
        state_nxt      = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Hold the port quiet while reset is low so no write can slip through.
    if (!reset) begin
      ram_en_c       = 1'b0;
      ram_we_c       = 1'b0;
      dma_gnt_c      = 1'b0;
      dma_done_c     = 1'b0;
      cpu_continue_c = 1'b1;
      cpu_rdata_c    = '0;
      dma_rdata_c    = '0;
    end
  end

  assign bus.ram_en       = ram_en_c;
  assign bus.ram_we       = ram_we_c;
  assign bus.ram_addr     = ram_addr_c;
  assign bus.ram_wdata    = ram_wdata_c;
  assign bus.dma_gnt      = dma_gnt_c;
  assign bus.dma_done     = dma_done_c;
  assign bus.dma_rdata    = dma_rdata_c;
  assign bus.cpu_continue = cpu_continue_c;
  assign bus.cpu_rdata    = cpu_rdata_c;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_stall_cnt <= 16'd0;
      dma_xfer_cnt  <= 16'd0;
    end else begin
      if (cpu_req && !cpu_continue_c && (cpu_stall_cnt != 16'hFFFF)) begin
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end
      if (dma_done_c && (dma_xfer_cnt != 16'hFFFF)) begin
        dma_xfer_cnt <= dma_xfer_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a transaction-level model of mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int MAX_CPU_RUN = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] cpu_stall_cnt;
  logic [15:0] dma_xfer_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_RUN(MAX_CPU_RUN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt),
    .dma_xfer_cnt  (dma_xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h20) return 32'h12345678;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous-read RAM macro
  logic [31:0] ram [256];
  bit          ram_wr [256];
  logic [31:0] ram_q;
  assign bus.ram_rdata = ram_q;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      ram_q <= ram_wr[bus.ram_addr] ? ram[bus.ram_addr] : init_val(bus.ram_addr);
      if (bus.ram_we) begin
        ram[bus.ram_addr]    <= bus.ram_wdata;
        ram_wr[bus.ram_addr] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory contents plus outstanding-read bookkeeping
  logic [31:0] m_mem [256];
  bit          m_wr [256];
  bit          m_cpu_pend, m_dma_pend;
  logic [31:0] m_cpu_data, m_dma_data;
  int          m_run;
  int          m_stall, m_xfer;
  bit          cpu_req, cpu_go, dma_go, was_pend;
  logic        e_en, e_we, e_gnt, e_done, e_cont;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_crd, e_drd, rd_val;

  initial begin
    m_cpu_pend = 0; m_dma_pend = 0; m_run = 0; m_stall = 0; m_xfer = 0;
    forever begin
      @(negedge clk);
      cpu_req = bus.cpu_rd | bus.cpu_wr;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_gnt = 0; e_done = 0;
      e_cont = 1; e_crd = '0; e_drd = '0; cpu_go = 0; dma_go = 0;
      if (!reset) begin
      end else if (m_cpu_pend) begin
        e_crd = m_cpu_data;
      end else if (m_dma_pend) begin
        e_drd  = m_dma_data;
        e_done = 1;
        e_cont = !cpu_req;
      end else begin
        dma_go = bus.dma_req && (!cpu_req || m_run >= MAX_CPU_RUN);
        cpu_go = cpu_req && !dma_go;
        if (cpu_go) begin
          e_en = 1; e_we = bus.cpu_wr; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
          e_cont = bus.cpu_wr;
        end else if (dma_go) begin
          e_gnt = 1; e_en = 1; e_we = bus.dma_wr; e_addr = bus.dma_addr;
          e_wdata = bus.dma_wdata; e_done = bus.dma_wr; e_cont = !cpu_req;
        end
      end
      chk("ram_en", 32'(bus.ram_en), 32'(e_en));
      chk("ram_we", 32'(bus.ram_we), 32'(e_we));
      chk("dma_gnt", 32'(bus.dma_gnt), 32'(e_gnt));
      chk("dma_done", 32'(bus.dma_done), 32'(e_done));
      chk("cpu_continue", 32'(bus.cpu_continue), 32'(e_cont));
      chk("cpu_rdata", bus.cpu_rdata, e_crd);
      chk("dma_rdata", bus.dma_rdata, e_drd);
      if (e_en) chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
      if (e_en && e_we) chk("ram_wdata", bus.ram_wdata, e_wdata);
`ifdef MEM_ARB_PERF_EN
      chk("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'(m_stall));
      chk("dma_xfer_cnt", 32'(dma_xfer_cnt), 32'(m_xfer));
      if (reset) begin
        if (cpu_req && !e_cont && m_stall < 16'hFFFF) m_stall++;
        if (e_done && m_xfer < 16'hFFFF) m_xfer++;
      end
`endif
      @(posedge clk);
      if (!reset) begin
        m_cpu_pend = 0; m_dma_pend = 0; m_run = 0; m_stall = 0; m_xfer = 0;
      end else begin
        was_pend = m_cpu_pend | m_dma_pend;
        m_cpu_pend = 0; m_dma_pend = 0;
        if (!was_pend) begin
          if (e_en && e_we) begin
            m_mem[e_addr] = e_wdata;
            m_wr[e_addr]  = 1;
          end else if (e_en) begin
            rd_val = m_wr[e_addr] ? m_mem[e_addr] : init_val(e_addr);
            if (cpu_go) begin m_cpu_pend = 1; m_cpu_data = rd_val; end
            else        begin m_dma_pend = 1; m_dma_data = rd_val; end
          end
          if (dma_go || !bus.dma_req) m_run = 0;
          else if (cpu_go && m_run < MAX_CPU_RUN) m_run++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_in(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma_in(input logic rq, input logic wr, input logic [7:0] a, input logic [31:0] d);
    bus.dma_req = rq; bus.dma_wr = wr; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  int grants;
  bit seen_gnt;
  int idx;

  initial begin
    reset = 1'b0;
    cpu_in(0, 0, 8'h00, 32'h0);
    dma_in(0, 0, 8'h00, 32'h0);
    @(negedge clk);
    chk("rst_cont", 32'(bus.cpu_continue), 32'd1);
    chk("rst_en", 32'(bus.ram_en), 32'd0);
    chk("rst_gnt", 32'(bus.dma_gnt), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // CPU store, no stall
    cpu_in(0, 1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_en", 32'(bus.ram_en), 32'd1);
    chk("t1_we", 32'(bus.ram_we), 32'd1);
    chk("t1_addr", 32'(bus.ram_addr), 32'h10);
    chk("t1_cont", 32'(bus.cpu_continue), 32'd1);
    step();

    // CPU load, one stall cycle
    cpu_in(1, 0, 8'h10, 32'h0);
    @(negedge clk);
    chk("t2_c0_cont", 32'(bus.cpu_continue), 32'd0);
    chk("t2_c0_en", 32'(bus.ram_en), 32'd1);
    step();
    @(negedge clk);
    chk("t2_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("t2_c1_cont", 32'(bus.cpu_continue), 32'd1);
    step();

    // DMA read with CPU idle
    cpu_in(0, 0, 8'h00, 32'h0);
    dma_in(1, 0, 8'h20, 32'h0);
    @(negedge clk);
    chk("t3_gnt", 32'(bus.dma_gnt), 32'd1);
    chk("t3_c0_cont", 32'(bus.cpu_continue), 32'd1);
    step();
    @(negedge clk);
    chk("t3_done", 32'(bus.dma_done), 32'd1);
    chk("t3_rdata", bus.dma_rdata, 32'h12345678);
    chk("t3_c1_cont", 32'(bus.cpu_continue), 32'd1);
    step();
    dma_in(0, 0, 8'h00, 32'h0);
    step();

    // CPU store and DMA write together: CPU first
    cpu_in(0, 1, 8'h40, 32'h11111111);
    dma_in(1, 1, 8'h30, 32'hCAFEF00D);
    @(negedge clk);
    chk("t4_c0_gnt", 32'(bus.dma_gnt), 32'd0);
    chk("t4_c0_addr", 32'(bus.ram_addr), 32'h40);
    step();
    cpu_in(0, 0, 8'h00, 32'h0);
    @(negedge clk);
    chk("t4_c1_gnt", 32'(bus.dma_gnt), 32'd1);
    chk("t4_c1_done", 32'(bus.dma_done), 32'd1);
    chk("t4_c1_addr", 32'(bus.ram_addr), 32'h30);
    step();
    dma_in(0, 0, 8'h00, 32'h0);
    step();

    // Back-to-back stores against a held DMA write: four CPU grants, then DMA
    grants = 0;
    seen_gnt = 0;
    for (int i = 0; i <= 10; i++) begin
      idx = (i <= 4) ? i : i - 1;
      cpu_in(0, 1, 8'(8'h50 + idx), 32'hA0000000 + 32'(idx));
      dma_in((i <= 4), 1, 8'h60, 32'h5A5A0060);
      @(negedge clk);
      if (bus.dma_gnt) seen_gnt = 1;
      if (!seen_gnt && bus.ram_we && bus.cpu_continue) grants++;
      if (i == 4) begin
        chk("t5_force_gnt", 32'(bus.dma_gnt), 32'd1);
        chk("t5_force_done", 32'(bus.dma_done), 32'd1);
        chk("t5_force_cont", 32'(bus.cpu_continue), 32'd0);
      end
      if (i == 5) begin
        chk("t5_resume_addr", 32'(bus.ram_addr), 32'h54);
        chk("t5_resume_cont", 32'(bus.cpu_continue), 32'd1);
      end
      step();
    end
    chk("t5_cpu_grants", 32'(grants), 32'd4);
    cpu_in(1, 0, 8'h60, 32'h0);
    dma_in(0, 0, 8'h00, 32'h0);
    step();
    @(negedge clk);
    chk("t5_dma_data", bus.cpu_rdata, 32'h5A5A0060);
    step();

    // CPU load blocked by a forced DMA read: two extra cycles
    dma_in(1, 0, 8'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cpu_in(0, 1, 8'(8'h80 + i), 32'(i));
      step();
    end
    cpu_in(1, 0, 8'h40, 32'h0);
    @(negedge clk);
    chk("t7_gnt", 32'(bus.dma_gnt), 32'd1);
    chk("t7_c0_cont", 32'(bus.cpu_continue), 32'd0);
    step();
    @(negedge clk);
    chk("t7_done", 32'(bus.dma_done), 32'd1);
    chk("t7_drdata", bus.dma_rdata, 32'hDEADBEEF);
    chk("t7_c1_cont", 32'(bus.cpu_continue), 32'd0);
    step();
    dma_in(0, 0, 8'h00, 32'h0);
    @(negedge clk);
    chk("t7_c2_cont", 32'(bus.cpu_continue), 32'd0);
    chk("t7_c2_addr", 32'(bus.ram_addr), 32'h40);
    step();
    @(negedge clk);
    chk("t7_crdata", bus.cpu_rdata, 32'h11111111);
    chk("t7_c3_cont", 32'(bus.cpu_continue), 32'd1);
    step();
    cpu_in(0, 0, 8'h00, 32'h0);
    step();

    // Reset asserted while a DMA read is outstanding
    dma_in(1, 0, 8'h20, 32'h0);
    @(negedge clk);
    chk("t6_gnt", 32'(bus.dma_gnt), 32'd1);
    step();
    reset = 1'b0;
    dma_in(0, 0, 8'h00, 32'h0);
    @(negedge clk);
    chk("t6_done", 32'(bus.dma_done), 32'd0);
    chk("t6_rst_cont", 32'(bus.cpu_continue), 32'd1);
    chk("t6_rst_en", 32'(bus.ram_en), 32'd0);
    chk("t6_rst_drdata", bus.dma_rdata, 32'd0);
    step(); step();
    reset = 1'b1;
    cpu_in(0, 1, 8'h70, 32'h00000077);
    @(negedge clk);
    chk("t6_we", 32'(bus.ram_we), 32'd1);
    chk("t6_cont", 32'(bus.cpu_continue), 32'd1);
    step();
    cpu_in(0, 0, 8'h00, 32'h0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single data-RAM port between the single-cycle CPU load/store path and a UART receive DMA engine.
- Converts the CPU's combinational memory access into a synchronous-read RAM access and stalls the CPU through cpu_continue, which drives the PC-update enable.
- Sits between the CPU datapath and the data-RAM macro.
- Fixed CPU priority, with a starvation guard that guarantees DMA progress.

Parameters:
ADDR_W, 8, word address width of data RAM
DATA_W, 32, data width
MAX_CPU_RUN, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced in (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_rd  in  1  CPU load request (held stable while cpu_continue=0)
cpu_wr  in  1  CPU store request (held stable while cpu_continue=0)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data, valid when cpu_continue=1 in CPU_RD
cpu_continue  out  1  1 = CPU may advance PC this cycle
dma_req  in  1  DMA request level, held until dma_done
dma_wr  in  1  1 = DMA write, 0 = DMA read
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  one-cycle pulse: DMA owns the RAM port this cycle
dma_done  out  1  one-cycle pulse: DMA transaction complete
dma_rdata  out  DATA_W  DMA read data, valid with dma_done on a read
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable (write commits at clk edge)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, one cycle after ram_en (synchronous read)

Behaviour:
- States: IDLE, CPU_RD, DMA_RD. Internal starve_cnt is 4 bits.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; starve_cnt=0.
  - ram_en=0, ram_we=0, dma_gnt=0, dma_done=0, cpu_continue=1, cpu_rdata=0, dma_rdata=0.
  - Any in-flight access is aborted. No write occurs while reset=0.
- IDLE arbitration:
  - cpu_req = cpu_rd | cpu_wr; cpu_wr wins if both are set (illegal, documented only).
  - force_dma = dma_req & (starve_cnt == MAX_CPU_RUN).
  - If cpu_req & ~force_dma: CPU is granted; the RAM port is driven from the cpu_* inputs.
    - Write: ram_en=1, ram_we=1, cpu_continue=1; state stays IDLE.
    - Read: ram_en=1, cpu_continue=0; next state CPU_RD.
    - If dma_req=1, starve_cnt increments (saturating at MAX_CPU_RUN).
  - Else if dma_req: DMA is granted; dma_gnt=1; the RAM port is driven from the dma_* inputs; starve_cnt clears to 0; cpu_continue = ~cpu_req.
    - Write: ram_we=1, dma_done=1 in the same cycle; state stays IDLE.
    - Read: ram_en=1; next state DMA_RD.
  - Else: RAM port idle, cpu_continue=1.
  - If dma_req=0, starve_cnt clears to 0.
- CPU_RD:
  - cpu_rdata = ram_rdata; cpu_continue=1; RAM port idle; next state IDLE.
- DMA_RD:
  - dma_rdata = ram_rdata; dma_done=1; RAM port idle.
  - cpu_continue = ~cpu_req (a pending CPU access waits).
  - Next state IDLE.
- Outputs cpu_rdata/dma_rdata: combinational in their completion state; 0 otherwise.
- Latency:
  - CPU store: 0 stall cycles.
  - CPU load: 1 stall cycle.
  - CPU access blocked by DMA: +1 cycle for a DMA write, +2 cycles for a DMA read.
- No DMA grant is ever issued in CPU_RD or DMA_RD. Back-to-back DMA is allowed only from IDLE.
- The arbiter does not decode addresses; all addresses are assumed RAM-mapped by upstream decode.

Optional Feature:
MEM_ARB_PERF_EN
- Defined:
  - Adds output ports cpu_stall_cnt[15:0] and dma_xfer_cnt[15:0].
  - cpu_stall_cnt increments on every cycle with cpu_req=1 and cpu_continue=0.
  - dma_xfer_cnt increments on every dma_done.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- CPU store addr 0x10, data 0xDEADBEEF, dma_req=0 -> same cycle ram_en=1, ram_we=1, ram_addr=0x10, cpu_continue=1; no stall.
- CPU load addr 0x10 after that store -> cycle0: cpu_continue=0, ram_en=1; cycle1: cpu_rdata=0xDEADBEEF, cpu_continue=1.
- CPU idle, DMA read addr 0x20 (RAM preloaded 0x12345678) -> cycle0: dma_gnt=1; cycle1: dma_done=1, dma_rdata=0x12345678; cpu_continue stays 1.
- dma_req (write, addr 0x30) and CPU store both asserted with starve_cnt=0 -> CPU granted first; DMA granted next cycle, once the CPU request drops or starve_cnt reaches 4.
- CPU issues 10 back-to-back stores with dma_req held high -> exactly 4 CPU grants, then one cycle with dma_gnt=1, dma_done=1, cpu_continue=0; the CPU store completes the following cycle.
- Reset pulled low in DMA_RD -> dma_done never pulses, state is IDLE, all outputs hold reset values; after release, a CPU store completes with 0 stall cycles.
